send_arbiter: RTL and testbench
===============================

Name: send_arbiter

Overview:
- Shares the framing block's send side (payload byte ring plus length FIFO) between NREQ message producers, e.g. command responders and async status reporters.
- Grants one requester at a time in round-robin order and streams its payload into the ring.
- Commits the message by pushing its payload length into the length FIFO, which makes the framer emit the frame.
- Guarantees frames are never interleaved and oversize payloads never reach the framer.

Parameters:
NREQ, 4, number of requesters (2..8)
LEN_BITS, 6, width of payload length (matches framer send_fifo_data)
MAX_PAYLOAD, 58, largest legal payload in bytes (frame len = payload+5 < 64); must be <= ring size - 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; level, held until done/reject
req_len  in  NREQ*LEN_BITS  payload length of requester i at [i*LEN_BITS +: LEN_BITS]; stable while req high
req_data  in  NREQ*8  first-word-fall-through byte of requester i at [i*8 +: 8]
gnt  out  NREQ  one-hot grant
req_rd  out  NREQ  byte of requester i consumed this cycle; present next byte next cycle
done  out  NREQ  1-cycle pulse: message committed
reject  out  NREQ  1-cycle pulse: message refused (oversize)
send_fifo_wr_en  out  1  length FIFO push
send_fifo_data  out  LEN_BITS  payload length pushed
send_fifo_full  in  1  length FIFO full
send_ring_data  out  8  payload byte to ring
send_ring_wr_en  out  1  ring write
send_ring_full  in  1  ring full
error  out  1  sticky: a reject occurred
clr  in  1  synchronous clear of error

Behaviour:
- Reset (rst_n low, async): state IDLE; rr pointer = NREQ-1, so requester 0 wins first; cnt, idx, len latch = 0; all outputs 0.
- States: IDLE, COPY, COMMIT, REJECT; 2-bit register.
- IDLE:
  - Arbitration happens only when |req and !send_fifo_full.
  - Winner = first requester with req set, searching from rr pointer+1 upward with wrap.
  - Latch idx and len = req_len[idx]; set cnt = len; rr pointer <= idx.
  - Next state: len > MAX_PAYLOAD -> REJECT; len == 0 -> COMMIT; else COPY.
  - gnt[idx] is registered and high from the cycle after arbitration through the COMMIT/REJECT cycle inclusive.
- COPY:
  - send_ring_wr_en = req_rd[idx] = !send_ring_full (combinational from state and full).
  - send_ring_data = req_data[idx].
  - On each write, cnt decrements; a write with cnt == 1 -> COMMIT.
  - While ring is full, hold with no write and no rd strobe.
  - req is ignored during COPY; dropping req mid-message is a protocol violation and the arbiter still finishes the count.
- COMMIT (exactly 1 cycle):
  - send_fifo_wr_en = 1, send_fifo_data = len, done[idx] = 1 -> IDLE.
  - send_fifo_full was checked at arbitration. This block is the only writer, so the push cannot overflow.
- REJECT (exactly 1 cycle): reject[idx] = 1, error <= 1, no ring or FIFO writes -> IDLE.
- Requester handshake: deassert req (or change req_len for a new message) in the cycle after done/reject. The arbiter sees the new level in IDLE.
- Fairness: a requester just served has lowest priority at the next arbitration.
- Throughput: 1 byte/cycle when ring not full. Per message: 1 arbitration cycle + len copy cycles + 1 commit cycle.
- clr clears error; a simultaneous REJECT and clr leaves error = 1 (set wins).
- Reset mid-COPY orphans uncommitted ring bytes. rst_n must be asserted only together with re-initialisation of the framer.
- send_fifo_data width = LEN_BITS; len compared as unsigned.

Decomposition:
- Shared package/include: state encodings, MAX_PAYLOAD default, frame overhead constant (5).
- Sub-module rr_arbiter: NREQ request vector + last-grant index -> one-hot winner and index, purely combinational.

Test Plan:
- Single requester 0, len=3, bytes 0x11,0x22,0x33 -> ring writes 0x11,0x22,0x33 on 3 consecutive cycles, then send_fifo_wr_en with data 3 and done[0] in the same cycle.
- req[0], req[2] simultaneous after reset, len 2 each -> requester 0 committed first, then requester 2; no interleaved ring bytes; second frame starts 1 cycle after first commit.
- All 4 requesters continuously re-requesting, len=1 -> grant order 0,1,2,3,0,...; each done spaced 3 cycles.
- Requester 1 len=59 -> reject[1] pulse, error=1, no ring/FIFO writes; clr pulse -> error=0.
- len=4 with send_ring_full forced high for 5 cycles after 2nd byte -> no write or rd strobe while full, bytes 3-4 follow release, exactly 4 writes total.
- send_fifo_full high with req[0] len=0 -> no grant; release -> FIFO push with data 0 and done[0], no ring writes. Assert rst_n low mid-COPY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/send_arbiter_pkg.sv
// send_arbiter_pkg: shared state encoding and framing constants for the send arbiter
// Contents: state_t (IDLE/COPY/COMMIT/REJECT), default max payload, frame overhead bytes
package send_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COPY   = 2'd1,
      COMMIT = 2'd2,
      REJECT = 2'd3
   } state_t;
   localparam int MAX_PAYLOAD_DEF = 58;
   localparam int FRAME_OVERHEAD  = 5;
endpackage

// File: rtl/send_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap
// Ports: req (request vector), last (previously granted index),
//        win (one-hot winner, zero when no request), idx (winner index)
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   idx
);
   localparam logic [IW:0] N = (IW+1)'(NREQ);
   logic found;
   // Walk from the lowest-priority slot (last itself) to the highest (last+1),
   // so the nearest requester overwrites any farther one.
   always_comb begin
      logic [IW:0] s;
      s     = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         s = {1'b0, last} + (IW+1)'(k);
         s = (s >= N) ? s - N : s;
         if (req[s[IW-1:0]]) begin
            idx   = s[IW-1:0];
            found = 1'b1;
         end
      end
      win = found ? (NREQ'(1) << idx) : '0;
   end
endmodule

// File: rtl/send_arbiter.sv
// send_arbiter: round-robin sharing of the framer send ring + length FIFO among NREQ producers
// Ports: req/req_len/req_data (producer side), gnt/req_rd/done/reject (per-producer strobes),
//        send_ring_* (payload bytes), send_fifo_* (length commit), error/clr (sticky reject flag)
module send_arbiter
   import send_arbiter_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int LEN_BITS    = 6,
   parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*LEN_BITS-1:0] req_len,
   input  logic [NREQ*8-1:0]        req_data,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          req_rd,
   output logic [NREQ-1:0]          done,
   output logic [NREQ-1:0]          reject,
   output logic                     send_fifo_wr_en,
   output logic [LEN_BITS-1:0]      send_fifo_data,
   input  logic                     send_fifo_full,
   output logic [7:0]               send_ring_data,
   output logic                     send_ring_wr_en,
   input  logic                     send_ring_full,
   output logic                     error,
   input  logic                     clr
);
   localparam int IW = $clog2(NREQ);
   localparam logic [LEN_BITS-1:0] MAXP = LEN_BITS'(MAX_PAYLOAD);
   state_t state, state_n;
   logic [IW-1:0]       idx, rr, w_idx;
   logic [LEN_BITS-1:0] len, cnt, w_len;
   logic [NREQ-1:0]     w_win, sel;
   logic                arb, wr;
   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req  (req),
      .last (rr),
      .win  (w_win),
      .idx  (w_idx)
   );
   assign w_len = req_len[w_idx*LEN_BITS +: LEN_BITS];
   assign sel   = NREQ'(1) << idx;
   // FIFO space is checked at arbitration: we are its only writer, so the later commit cannot overflow.
   assign arb   = state == IDLE && |w_win && !send_fifo_full;
   assign wr    = state == COPY && !send_ring_full;
   always_comb begin
      state_n         = state;
      gnt             = state != IDLE ? sel : '0;
      req_rd          = wr ? sel : '0;
      send_ring_wr_en = wr;
      send_ring_data  = state == COPY ? req_data[idx*8 +: 8] : 8'h00;
      send_fifo_wr_en = state == COMMIT;
      send_fifo_data  = state == COMMIT ? len : '0;
      done            = state == COMMIT ? sel : '0;
      reject          = state == REJECT ? sel : '0;
      case (state)
         IDLE:    state_n = !arb ? IDLE : w_len > MAXP ? REJECT : w_len == '0 ? COMMIT : COPY;
         COPY:    state_n = (wr && cnt == LEN_BITS'(1)) ? COMMIT : COPY;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         rr    <= IW'(NREQ-1);
         len   <= '0;
         cnt   <= '0;
         error <= 1'b0;
      end else begin
         state <= state_n;
         if (arb) begin
            idx <= w_idx;
            rr  <= w_idx;
            len <= w_len;
            cnt <= w_len;
         end else if (wr) begin
            cnt <= cnt - LEN_BITS'(1);
         end
         // A reject in the same cycle as clr keeps the flag set.
         error <= state == REJECT ? 1'b1 : clr ? 1'b0 : error;
      end
   end
endmodule

// File: tb/tb_send_arbiter.sv
// tb_send_arbiter: directed self-checking bench for send_arbiter
module tb_send_arbiter;
   localparam int NREQ = 4;
   localparam int LB   = 6;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*LB-1:0] req_len = '0;
   logic [NREQ*8-1:0] req_data;
   logic [NREQ-1:0]   gnt, req_rd, done, reject;
   logic              send_fifo_wr_en, send_ring_wr_en, error;
   logic [LB-1:0]     send_fifo_data;
   logic [7:0]        send_ring_data;
   logic              send_fifo_full = 1'b0;
   logic              send_ring_full = 1'b0;
   logic              clr = 1'b0;
   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int push_cnt = 0;
   int base;
   logic found;
   logic [7:0] ptr [NREQ];
   send_arbiter #(.NREQ(NREQ), .LEN_BITS(LB), .MAX_PAYLOAD(58)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .req_data(req_data),
      .gnt(gnt), .req_rd(req_rd), .done(done), .reject(reject),
      .send_fifo_wr_en(send_fifo_wr_en), .send_fifo_data(send_fifo_data),
      .send_fifo_full(send_fifo_full), .send_ring_data(send_ring_data),
      .send_ring_wr_en(send_ring_wr_en), .send_ring_full(send_ring_full),
      .error(error), .clr(clr)
   );
   always #5 clk = ~clk;
   function automatic logic [7:0] byte_of(input int i, input int k);
      return 8'((i << 6) + (k + 1) * 17);
   endfunction
   // Producer model: FWFT byte stream per requester, restarting on each new message.
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
         if (!rst_n) ptr[i] <= '0;
         else if (done[i] || reject[i]) ptr[i] <= '0;
         else if (req_rd[i]) ptr[i] <= ptr[i] + 8'd1;
      end
   end
   always_comb begin
      req_data = '0;
      for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = byte_of(i, int'(ptr[i]));
   end
   always @(posedge clk) begin
      if (send_ring_wr_en) wr_cnt <= wr_cnt + 1;
      if (send_fifo_wr_en) push_cnt <= push_cnt + 1;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(negedge clk);
      #1;
   endtask
   task automatic rst_pulse;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
   endtask
   initial begin
      step;
      step;
      chk("rst_gnt", gnt, 0);
      chk("rst_wr", send_ring_wr_en, 0);
      chk("rst_push", send_fifo_wr_en, 0);
      chk("rst_done", done, 0);
      chk("rst_err", error, 0);
      rst_n = 1'b1;
      // single requester, len 3
      req = 4'b0001;
      req_len[0*LB +: LB] = 6'd3;
      step; chk("t1_gnt", gnt, 4'b0001); chk("t1_b0", send_ring_data, 8'h11); chk("t1_rd", req_rd, 4'b0001);
      step; chk("t1_b1", send_ring_data, 8'h22); chk("t1_wr1", send_ring_wr_en, 1);
      step; chk("t1_b2", send_ring_data, 8'h33); chk("t1_wr2", send_ring_wr_en, 1);
      step; chk("t1_push", send_fifo_wr_en, 1); chk("t1_len", send_fifo_data, 3); chk("t1_done", done, 4'b0001);
      chk("t1_nowr", send_ring_wr_en, 0); chk("t1_cnt", wr_cnt, 3);
      req = 4'b0000;
      step; chk("t1_idle", gnt, 0); chk("t1_done_off", done, 0); chk("t1_pushes", push_cnt, 1);
      // two simultaneous requesters from reset
      rst_pulse;
      req = 4'b0101;
      req_len[0*LB +: LB] = 6'd2;
      req_len[2*LB +: LB] = 6'd2;
      step; chk("t2_gnt0", gnt, 4'b0001); chk("t2_a0", send_ring_data, 8'h11);
      step; chk("t2_a1", send_ring_data, 8'h22);
      step; chk("t2_done0", done, 4'b0001); chk("t2_len0", send_fifo_data, 2);
      req = 4'b0100;
      step; chk("t2_gap_gnt", gnt, 0); chk("t2_gap_wr", send_ring_wr_en, 0);
      step; chk("t2_gnt2", gnt, 4'b0100); chk("t2_b0", send_ring_data, 8'h91);
      step; chk("t2_b1", send_ring_data, 8'hA2);
      step; chk("t2_done2", done, 4'b0100); chk("t2_len2", send_fifo_data, 2);
      req = 4'b0000;
      // all four continuously requesting, len 1
      rst_pulse;
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) req_len[i*LB +: LB] = 6'd1;
      for (int m = 0; m < 8; m++) begin
         step; chk("t3_gnt", gnt, 32'(1 << (m % 4))); chk("t3_byte", send_ring_data, byte_of(m % 4, 0));
         step; chk("t3_done", done, 32'(1 << (m % 4)));
         if (m == 7) req = 4'b0000;
         step; chk("t3_idle", gnt, 0);
      end
      // oversize reject, clr, and reject-vs-clr priority
      base = wr_cnt + push_cnt;
      req = 4'b0010;
      req_len[1*LB +: LB] = 6'd59;
      step; chk("t4_rej", reject, 4'b0010); chk("t4_gnt", gnt, 4'b0010); chk("t4_wr", send_ring_wr_en, 0); chk("t4_push", send_fifo_wr_en, 0);
      req = 4'b0000;
      step; chk("t4_err", error, 1); chk("t4_rej_off", reject, 0);
      clr = 1'b1;
      step; chk("t4_clr", error, 0);
      req = 4'b0010;
      step; chk("t4_rej2", reject, 4'b0010);
      req = 4'b0000;
      step; chk("t4_setwins", error, 1);
      clr = 1'b0;
      step; chk("t4_held", error, 1);
      clr = 1'b1;
      step; chk("t4_clr2", error, 0); chk("t4_nowrites", wr_cnt + push_cnt, base);
      clr = 1'b0;
      // largest legal payload
      base = wr_cnt;
      req = 4'b1000;
      req_len[3*LB +: LB] = 6'd58;
      found = 1'b0;
      for (int k = 0; k < 80 && !found; k++) begin
         step;
         found = done[3];
      end
      chk("t5_done58", found, 1); chk("t5_len58", send_fifo_data, 58); chk("t5_wr58", wr_cnt - base, 58);
      req = 4'b0000;
      step;
      // ring backpressure
      base = wr_cnt;
      req = 4'b0001;
      req_len[0*LB +: LB] = 6'd4;
      step; chk("t6_b0", send_ring_data, 8'h11);
      step; chk("t6_b1", send_ring_data, 8'h22);
      step; chk("t6_b2", send_ring_data, 8'h33);
      send_ring_full = 1'b1;
      #1; chk("t6_full_wr", send_ring_wr_en, 0); chk("t6_full_rd", req_rd, 0);
      for (int k = 0; k < 4; k++) begin
         step; chk("t6_hold_wr", send_ring_wr_en, 0); chk("t6_hold_rd", req_rd, 0); chk("t6_hold_b", send_ring_data, 8'h33);
      end
      step;
      send_ring_full = 1'b0;
      #1; chk("t6_rel_b2", send_ring_data, 8'h33); chk("t6_rel_wr", send_ring_wr_en, 1);
      step; chk("t6_b3", send_ring_data, 8'h44);
      step; chk("t6_done", done, 4'b0001); chk("t6_len", send_fifo_data, 4); chk("t6_writes", wr_cnt - base, 4);
      req = 4'b0000;
      // zero-length message held off by a full length FIFO
      base = wr_cnt;
      send_fifo_full = 1'b1;
      req = 4'b0001;
      req_len[0*LB +: LB] = 6'd0;
      for (int k = 0; k < 3; k++) begin
         step; chk("t7_nognt", gnt, 0); chk("t7_nopush", send_fifo_wr_en, 0);
      end
      send_fifo_full = 1'b0;
      step; chk("t7_push", send_fifo_wr_en, 1); chk("t7_len0", send_fifo_data, 0); chk("t7_done", done, 4'b0001);
      chk("t7_noring", wr_cnt - base, 0);
      req = 4'b0000;
      // asynchronous reset in the middle of a copy
      step;
      req = 4'b0100;
      req_len[2*LB +: LB] = 6'd5;
      step; chk("t8_copy", send_ring_wr_en, 1); chk("t8_gnt", gnt, 4'b0100);
      rst_n = 1'b0;
      #1;
      chk("t8_gnt0", gnt, 0); chk("t8_wr0", send_ring_wr_en, 0); chk("t8_rd0", req_rd, 0);
      chk("t8_data0", send_ring_data, 0); chk("t8_push0", send_fifo_wr_en, 0); chk("t8_done0", done, 0);
      step;
      req = 4'b0000;
      rst_n = 1'b1;
      step; chk("t8_idle", gnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
